// File: rtl/seg_display_scan.sv
// seg_display_scan: 4-digit common-anode 7-segment scanner with double-buffered load handshake.
// Optional per-digit blinking is compiled in when SEG_SCAN_BLINK_EN is defined.
module seg_display_scan #(
    parameter int SCAN_TIME    = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        load,
    input  logic [15:0] data,
    input  logic [3:0]  dp,
    input  logic [3:0]  blank,
    input  logic [3:0]  blink,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp_n,
    output logic        pending,
    output logic        frame_load
);
    localparam int CW = $clog2(SCAN_TIME);
    localparam logic [6:0] HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  dp;
        logic [3:0]  blank;
    } disp_t;

    disp_t         staging, shadow;
    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic          last, wrap, xfer, dark;
    logic [3:0]    digit;

    assign last  = cnt == CW'(SCAN_TIME - 1);
    assign wrap  = last && idx == 2'd3;
    // a load on the wrap cycle wins; the transfer slips to the next wrap
    assign xfer  = wrap && pending && !load;
    assign digit = shadow.data[{idx, 2'b00} +: 4];

`ifdef SEG_SCAN_BLINK_EN
    localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
    logic [FW-1:0] frame_cnt;
    logic          blink_phase;
    logic [3:0]    stg_blink, shd_blink;
    logic          frame_last;

    assign frame_last = frame_cnt == FW'(BLINK_FRAMES - 1);
    assign dark       = shadow.blank[idx] | (blink_phase & shd_blink[idx]);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            stg_blink   <= '0;
            shd_blink   <= '0;
        end else begin
            if (wrap) frame_cnt <= frame_last ? '0 : frame_cnt + 1'b1;
            if (wrap && frame_last) blink_phase <= ~blink_phase;
            if (load) stg_blink <= blink;
            if (xfer) shd_blink <= stg_blink;
        end
    end
`else
    logic unused_blink;
    assign unused_blink = ^blink;
    assign dark         = shadow.blank[idx];
`endif

    always_ff @(posedge CLK) begin
        if (Reset) begin
            cnt        <= '0;
            idx        <= '0;
            staging    <= '0;
            shadow     <= '0;
            pending    <= 1'b0;
            frame_load <= 1'b0;
            an         <= 4'hF;
            seg        <= 7'h7F;
            dp_n       <= 1'b1;
        end else begin
            cnt        <= last ? '0 : cnt + 1'b1;
            idx        <= last ? idx + 1'b1 : idx;
            frame_load <= xfer;
            if (load) begin
                staging <= '{data: data, dp: dp, blank: blank};
                pending <= 1'b1;
            end else if (xfer) begin
                shadow  <= staging;
                pending <= 1'b0;
            end
            // first cycle of each slot keeps all anodes off to avoid ghosting
            an         <= cnt == '0 ? 4'hF : ~(4'b0001 << idx);
            seg        <= dark ? 7'h7F : HEX[digit];
            dp_n       <= dark | ~shadow.dp[idx];
        end
    end
endmodule

// File: tb/tb_seg_display_scan.sv
// tb_seg_display_scan: randomized and directed checks of seg_display_scan against a cycle-count based model.
module tb_seg_display_scan;
    localparam int ST = 4;
    localparam int BF = 2;
    localparam int FR = 4 * ST;
    localparam logic [6:0] HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic        CLK = 1'b0, Reset = 1'b1, load = 1'b0;
    logic [15:0] data = '0;
    logic [3:0]  dp = '0, blank = '0, blink = '0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp_n, pending, frame_load;

    seg_display_scan #(.SCAN_TIME(ST), .BLINK_FRAMES(BF)) dut (
        .CLK(CLK), .Reset(Reset), .load(load), .data(data), .dp(dp), .blank(blank),
        .blink(blink), .an(an), .seg(seg), .dp_n(dp_n), .pending(pending), .frame_load(frame_load)
    );

    always #5 CLK = ~CLK;

    // model: position in the scan follows from cycles since reset
    int          n;
    logic [15:0] s_data, m_data;
    logic [3:0]  s_dp, s_blank, s_blink, m_dp, m_blank, m_blink;
    logic        m_pend, exp_fl, exp_dp_n;
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    bit          chk_on = 0;
    int          passed = 0, total = 0;

    function automatic logic phase_of(input int t);
`ifdef SEG_SCAN_BLINK_EN
        return ((t / FR) / BF) % 2 == 1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    always @(negedge CLK) if (chk_on) begin
        check("an", an, exp_an);
        check("seg", seg, exp_seg);
        check("dp_n", dp_n, exp_dp_n);
        check("pending", pending, m_pend);
        check("frame_load", frame_load, exp_fl);
    end

    task automatic model(input logic r, input logic ld, input logic [15:0] d,
                         input logic [3:0] p, input logic [3:0] b, input logic [3:0] bl);
        int  c, k;
        logic wr, dark;
        if (r) begin
            n = 0; m_pend = 0;
            {s_data, s_dp, s_blank, s_blink} = '0;
            {m_data, m_dp, m_blank, m_blink} = '0;
            exp_an = 4'hF; exp_seg = 7'h7F; exp_dp_n = 1; exp_fl = 0;
            chk_on = 1;
        end else begin
            c = n % ST;
            k = (n / ST) % 4;
            wr = (n % FR) == FR - 1;
            dark = m_blank[k] | (phase_of(n) & m_blink[k]);
            exp_an = c == 0 ? 4'hF : 4'hF ^ (4'b0001 << k);
            exp_seg = dark ? 7'h7F : HEX[m_data[4*k +: 4]];
            exp_dp_n = dark | ~m_dp[k];
            exp_fl = wr & m_pend & ~ld;
            if (ld) begin
                {s_data, s_dp, s_blank, s_blink} = {d, p, b, bl};
                m_pend = 1;
            end else if (wr && m_pend) begin
                {m_data, m_dp, m_blank, m_blink} = {s_data, s_dp, s_blank, s_blink};
                m_pend = 0;
            end
            n++;
        end
    endtask

    task automatic step(input logic r, input logic ld, input logic [15:0] d,
                        input logic [3:0] p, input logic [3:0] b, input logic [3:0] bl);
        Reset = r; load = ld; data = d; dp = p; blank = b; blink = bl;
        @(posedge CLK);
        model(r, ld, d, p, b, bl);
        @(negedge CLK);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 16'h0, 4'h0, 4'h0, 4'h0);
    endtask

    task automatic go_to(input int t);
        for (int i = 0; i < FR && n % FR != t; i++) idle();
    endtask

    initial begin
        int fl, lit;
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        check("rst_an", an, 4'hF);
        check("rst_seg", seg, 7'h7F);
        check("rst_dp_n", dp_n, 1'b1);
        check("rst_pending", pending, 1'b0);
        check("rst_frame_load", frame_load, 1'b0);
        idle();
        check("dead_an", an, 4'hF);
        idle();
        check("zero_an", an, 4'hE);
        check("zero_seg", seg, 7'h40);
        go_to(5);
        step(0, 1, 16'h12AF, 4'b0100, 4'b0000, 4'b0000);
        check("load_pending", pending, 1'b1);
        go_to(0);
        check("wrap_frame_load", frame_load, 1'b1);
        check("wrap_pending", pending, 1'b0);
        go_to(2);
        check("d0_an", an, 4'hE);
        check("d0_seg", seg, 7'h0E);
        go_to(6);
        check("d1_an", an, 4'hD);
        check("d1_seg", seg, 7'h08);
        go_to(10);
        check("d2_an", an, 4'hB);
        check("d2_seg", seg, 7'h24);
        check("d2_dp_n", dp_n, 1'b0);
        go_to(14);
        check("d3_an", an, 4'h7);
        check("d3_seg", seg, 7'h79);
        go_to(3);
        step(0, 1, 16'h1111, 0, 0, 0);
        idle();
        step(0, 1, 16'h2222, 0, 0, 0);
        fl = 0;
        repeat (FR) begin idle(); fl += int'(frame_load); end
        check("two_loads_pulses", fl, 1);
        go_to(2);
        check("two_loads_seg", seg, 7'h24);
        go_to(15);
        step(0, 1, 16'h3333, 0, 0, 0);
        check("wrap_load_no_pulse", frame_load, 1'b0);
        check("wrap_load_pending", pending, 1'b1);
        fl = 0;
        repeat (FR - 1) begin idle(); fl += int'(frame_load); end
        check("wrap_load_quiet", fl, 0);
        idle();
        check("wrap_load_late_pulse", frame_load, 1'b1);
        go_to(2);
        check("wrap_load_seg", seg, 7'h30);
        step(0, 1, 16'h0000, 4'b1111, 4'b1010, 4'b0000);
        go_to(0);
        go_to(6);
        check("blank_an", an, 4'hD);
        check("blank_seg", seg, 7'h7F);
        check("blank_dp_n", dp_n, 1'b1);
        go_to(10);
        check("unblank_seg", seg, 7'h40);
        step(0, 1, 16'h5555, 4'b0000, 4'b0000, 4'b0001);
        go_to(0);
        lit = 0;
        repeat (8) begin
            go_to(2);
            lit += int'(seg != 7'h7F);
            idle();
        end
`ifdef SEG_SCAN_BLINK_EN
        check("blink_lit_frames", lit, 4);
`else
        check("blink_lit_frames", lit, 8);
`endif
        go_to(7);
        step(1, 0, 0, 0, 0, 0);
        check("midreset_an", an, 4'hF);
        check("midreset_seg", seg, 7'h7F);
        check("midreset_pending", pending, 1'b0);
        repeat (3000) begin
            step($urandom_range(0, 299) == 0, $urandom_range(0, 11) == 0, 16'($urandom),
                 4'($urandom), 4'($urandom_range(0, 3) == 0 ? $urandom : 0), 4'($urandom));
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
